// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if
// Bundle between the EX stage and the iterative multiply/divide engine.
//   flush      : pipeline flush; aborts any operation in flight
//   stall_all  : stall from another stage; EX instruction does not advance
//   funct      : EX funct (MULT=0x18, MULTU=0x19, DIV=0x1A, DIVU=0x1B)
//   operand_1  : rs value (multiplicand / dividend)
//   operand_2  : rt value (multiplier / divisor)
//   done       : result valid for the instruction currently in EX
//   result     : {HI, LO}; mult: product, div: {remainder, quotient}
//   busy       : engine is iterating
// master = EX stage side, slave = mult_div_unit side.
interface mult_div_unit_if;
    logic        flush;
    logic        stall_all;
    logic [5:0]  funct;
    logic [31:0] operand_1;
    logic [31:0] operand_2;
    logic        done;
    logic [63:0] result;
    logic        busy;

    modport master (
        output flush, stall_all, funct, operand_1, operand_2,
        input  done, result, busy
    );

    modport slave (
        input  flush, stall_all, funct, operand_1, operand_2,
        output done, result, busy
    );
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit
// Iterative 32x32 multiply / 32/32 divide engine beside the EX stage.
// Magnitudes are captured in IDLE, 32 CALC cycles compute one bit each
// (shift-add for multiply, restoring division for divide), and the
// sign-corrected {HI, LO} is registered on the last CALC edge. done is
// high in DONE and is held there while stall_all is asserted.
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : mult_div_unit_if.slave (flush, stall_all, funct, operands,
//         done, result, busy)
module mult_div_unit (
    input logic            clk,
    input logic            rst,
    mult_div_unit_if.slave bus
);

    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic [4:0]  count_r;
    logic        is_div_r;
    logic        is_signed_r;
    logic        sign1_r;
    logic        sign2_r;
    logic        div_zero_r;
    logic [31:0] hi_r;        // mult: upper accumulator; div: partial remainder
    logic [31:0] lo_r;        // mult: lower product / multiplier; div: quotient / dividend
    logic [31:0] opb_r;       // mult: multiplicand; div: divisor
    logic [63:0] result_r;
    logic        done_r;
    logic        busy_r;

    logic        start_s;
    logic        start_signed_s;
    logic        start_div_s;
    logic [32:0] mul_sum_s;
    logic [32:0] div_shift_s;
    logic [32:0] div_diff_s;
    logic [31:0] hi_step_s;
    logic [31:0] lo_step_s;
    logic [31:0] quot_s;
    logic [31:0] rem_s;
    logic [63:0] prod_s;
    logic [63:0] final_s;

    // Magnitude of a 32-bit operand; unsigned ops pass the raw value through.
    function automatic logic [31:0] magnitude(input logic [31:0] v, input logic signed_op);
        return (signed_op && v[31]) ? (32'd0 - v) : v;
    endfunction

    // Decode funct into start request and op attributes.
    always_comb begin
        start_s        = 1'b0;
        start_signed_s = 1'b0;
        start_div_s    = 1'b0;
        case (bus.funct)
            FUNCT_MULT:  begin start_s = 1'b1; start_signed_s = 1'b1; end
            FUNCT_MULTU: begin start_s = 1'b1; end
            FUNCT_DIV:   begin start_s = 1'b1; start_signed_s = 1'b1; start_div_s = 1'b1; end
            FUNCT_DIVU:  begin start_s = 1'b1; start_div_s = 1'b1; end
            default:     begin start_s = 1'b0; end
        endcase
    end

    // One iteration step of either shift-add multiply or restoring divide.
    always_comb begin
        mul_sum_s   = {1'b0, hi_r} + (lo_r[0] ? {1'b0, opb_r} : 33'd0);
        div_shift_s = {hi_r, lo_r[31]};
        div_diff_s  = div_shift_s - {1'b0, opb_r};
        if (is_div_r) begin
            if (!div_diff_s[32]) begin
                hi_step_s = div_diff_s[31:0];
                lo_step_s = {lo_r[30:0], 1'b1};
            end else begin
                hi_step_s = div_shift_s[31:0];
                lo_step_s = {lo_r[30:0], 1'b0};
            end
        end else begin
            hi_step_s = mul_sum_s[32:1];
            lo_step_s = {mul_sum_s[0], lo_r[31:1]};
        end
    end

    // Sign correction applied to the value produced by the final step.
    always_comb begin
        prod_s = {hi_step_s, lo_step_s};
        quot_s = (is_signed_r && (sign1_r ^ sign2_r)) ? (32'd0 - lo_step_s) : lo_step_s;
        rem_s  = (is_signed_r && sign1_r) ? (32'd0 - hi_step_s) : hi_step_s;
        if (is_div_r) begin
            // Divide by zero: remainder naturally equals the dividend,
            // quotient is forced to all ones.
            final_s = {rem_s, (div_zero_r ? 32'hFFFF_FFFF : quot_s)};
        end else if (is_signed_r && (sign1_r ^ sign2_r)) begin
            final_s = 64'd0 - prod_s;
        end else begin
            final_s = prod_s;
        end
    end

    // Next-state logic; flush wins over everything including a new start.
    always_comb begin
        state_next_s = state_r;
        if (bus.flush) begin
            state_next_s = IDLE;
        end else begin
            case (state_r)
                IDLE:    state_next_s = start_s ? CALC : IDLE;
                CALC:    state_next_s = (count_r == 5'd31) ? DONE : CALC;
                DONE:    state_next_s = bus.stall_all ? DONE : IDLE;
                default: state_next_s = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Operand capture, iteration datapath, result and status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r     <= 5'd0;
            is_div_r    <= 1'b0;
            is_signed_r <= 1'b0;
            sign1_r     <= 1'b0;
            sign2_r     <= 1'b0;
            div_zero_r  <= 1'b0;
            hi_r        <= 32'd0;
            lo_r        <= 32'd0;
            opb_r       <= 32'd0;
            result_r    <= 64'd0;
            done_r      <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            done_r <= (state_next_s == DONE);
            busy_r <= (state_next_s == CALC);
            case (state_r)
                IDLE: begin
                    if (!bus.flush && start_s) begin
                        count_r     <= 5'd0;
                        is_div_r    <= start_div_s;
                        is_signed_r <= start_signed_s;
                        sign1_r     <= bus.operand_1[31];
                        sign2_r     <= bus.operand_2[31];
                        div_zero_r  <= start_div_s && (bus.operand_2 == 32'd0);
                        hi_r        <= 32'd0;
                        lo_r        <= magnitude(bus.operand_1, start_signed_s);
                        opb_r       <= magnitude(bus.operand_2, start_signed_s);
                    end
                end
                CALC: begin
                    if (!bus.flush) begin
                        hi_r    <= hi_step_s;
                        lo_r    <= lo_step_s;
                        count_r <= count_r + 5'd1;
                        if (count_r == 5'd31) begin
                            result_r <= final_s;
                        end
                    end
                end
                default: begin
                    count_r <= count_r;
                end
            endcase
        end
    end

    assign bus.done   = done_r;
    assign bus.result = result_r;
    assign bus.busy   = busy_r;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: the driver pushes expected
// {result, done cycle} entries; a negedge monitor pops and compares on
// every rising edge of done and checks that result holds while done stays up.
module tb_mult_div_unit;

    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    typedef struct {
        logic [63:0] res;
        int          cyc;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   failures;
    exp_t exp_q[$];

    mult_div_unit_if bus ();

    mult_div_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Monitor: compare on done rising, check hold while done stays high.
    initial begin
        logic        done_q;
        logic [63:0] held_res;
        exp_t        e;
        done_q   = 1'b0;
        held_res = 64'd0;
        forever begin
            @(negedge clk);
            if (bus.done && !done_q) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_done: cycle %0d result %h, no operation expected", cyc, bus.result);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.result !== e.res || cyc != e.cyc) begin
                        failures++;
                        $display("FAIL op_result: got %h at cycle %0d, want %h at cycle %0d", bus.result, cyc, e.res, e.cyc);
                    end
                end
                held_res = bus.result;
            end else if (bus.done && done_q) begin
                checks++;
                if (bus.result !== held_res) begin
                    failures++;
                    $display("FAIL held_result: got %h, want %h", bus.result, held_res);
                end
            end
            done_q = bus.done;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got %h, want %h", name, act, want);
        end
    endtask

    // Present an op in the current cycle; optionally expect done 33 cycles later.
    task automatic present(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] want, input bit expect_it);
        exp_t e;
        bus.funct     = f;
        bus.operand_1 = a;
        bus.operand_2 = b;
        if (expect_it) begin
            e.res = want;
            e.cyc = cyc + 33;
            exp_q.push_back(e);
        end
    endtask

    // Wait (bounded) for done, scrambling operands mid-CALC; then hold
    // stall_all for 'stall' cycles and retire into IDLE.
    task automatic finish_op(input int stall);
        int n;
        n = 0;
        while (!bus.done && n < 40) begin
            tick(1);
            n++;
            if (n == 5) begin
                bus.operand_1 = ~bus.operand_1;
                bus.operand_2 = bus.operand_2 ^ 32'h5A5A_0001;
            end
        end
        if (!bus.done) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: done still %b after %0d cycles, want 1", bus.done, n);
        end
        if (stall > 0) begin
            bus.stall_all = 1'b1;
            tick(stall);
            bus.stall_all = 1'b0;
        end
        tick(1);
        bus.funct = 6'h00;
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst           = 1'b1;
        bus.flush     = 1'b0;
        bus.stall_all = 1'b0;
        bus.funct     = 6'h00;
        bus.operand_1 = 32'd0;
        bus.operand_2 = 32'd0;
        tick(3);
        rst = 1'b0;
        check("reset_state", {bus.result, bus.done, bus.busy}, {64'd0, 1'b0, 1'b0});
        tick(2);

        present(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b1);
        tick(1);
        check("busy_in_calc", {63'd0, bus.busy}, 64'd1);
        finish_op(0);
        present(F_MULT,  32'hFFFF_FFFD, 32'd7,        64'hFFFF_FFFF_FFFF_FFEB, 1'b1); finish_op(0);
        present(F_MULT,  32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b1); finish_op(0);
        present(F_DIV,   32'hFFFF_FFF9, 32'd2,        64'hFFFF_FFFF_FFFF_FFFD, 1'b1); finish_op(0);
        present(F_DIVU,  32'd7,         32'd2,        64'h0000_0001_0000_0003, 1'b1); finish_op(0);
        present(F_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b1); finish_op(0);
        present(F_DIVU,  32'h0000_1234, 32'd0,        64'h0000_1234_FFFF_FFFF, 1'b1); finish_op(0);
        present(F_DIV,   32'hFFFF_FFF9, 32'd0,        64'hFFFF_FFF9_FFFF_FFFF, 1'b1); finish_op(0);

        // Flush mid-operation: no done for the aborted op, restart next cycle.
        present(F_MULTU, 32'd5, 32'd6, 64'd0, 1'b0);
        tick(10);
        check("busy_before_flush", {63'd0, bus.busy}, 64'd1);
        bus.flush = 1'b1;
        tick(1);
        bus.flush = 1'b0;
        check("idle_after_flush", {62'd0, bus.done, bus.busy}, 64'd0);
        present(F_MULTU, 32'd5, 32'd6, 64'h0000_0000_0000_001E, 1'b1);
        finish_op(3);
        present(F_DIVU, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 1'b1);
        finish_op(0);

        // Asynchronous reset mid-operation clears everything.
        present(F_MULT, 32'hFFFF_FFFD, 32'd7, 64'd0, 1'b0);
        tick(5);
        bus.funct = 6'h00;
        rst = 1'b1;
        #1;
        check("reset_mid_op", {bus.result, bus.done, bus.busy}, {64'd0, 1'b0, 1'b0});
        tick(2);
        rst = 1'b0;
        tick(40);

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
